adc_widthconv: RTL and testbench

- Receive-side counterpart of the DAC width converter. Takes one 8-bit offset-binary ADC sample per valid cycle plus a per-sample control/marker bit.
- Converts each sample to two's-complement and packs four samples into one 36-bit FIFO word, laid out as {cw[3],d[31:24], cw[2],d[23:16], cw[1],d[15:8], cw[0],d[7:0]}. The first sample goes in lane 0.
- Sits between the ADC capture logic and the 36-bit write port of the ADC-to-host async FIFO.
- Holds words while the FIFO is full, and drops and counts samples on overrun.

---
 rtl/radio_pkg.sv | 24 ++
 rtl/adc_lane_assembler.sv | 124 ++++++++++++
 rtl/adc_widthconv.sv | 84 ++++++++
 tb/tb_adc_widthconv.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// Shared radio datapath constants and the 36-bit FIFO word layout used by
// both the ADC and DAC width converters.
package radio_pkg;

    localparam int ADC_SAMPLE_W = 8;
    localparam int LANES        = 4;
    localparam int FIFO_WORD_W  = 36;

    localparam logic [ADC_SAMPLE_W-1:0] ADC_OFFSET = 8'h80;
    localparam logic [ADC_SAMPLE_W-1:0] PAD_SAMPLE = 8'h00;

    typedef struct packed {
        logic [LANES-1:0]              cw;
        logic [LANES*ADC_SAMPLE_W-1:0] data;
    } lane_word_t;

    // Each control bit sits directly above its sample byte.
    function automatic logic [FIFO_WORD_W-1:0] pack36(input logic [31:0] data32,
                                                     input logic [3:0]  cw4);
        pack36 = {cw4[3], data32[31:24], cw4[2], data32[23:16],
                  cw4[1], data32[15:8],  cw4[0], data32[7:0]};
    endfunction

endpackage

// File: rtl/adc_lane_assembler.sv
// Assembles converted ADC samples into a four-lane word, handling flush and
// flag-alignment padding, and holds one finished word when the next stage is busy.
module adc_lane_assembler
    import radio_pkg::*;
#(
    parameter bit CONVERT_OFFSET = 1'b1,
    parameter bit ALIGN_ON_FLAG  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_flag,
    input  logic        flush,
    input  logic        p_free,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [3:0]  word_cw,
    output logic        drop
);

    localparam logic [31:0] EMPTY_DATA = {LANES{PAD_SAMPLE}};

    logic [31:0] a_data;
    logic [3:0]  a_cw;
    logic [1:0]  lane;
    logic        a_full;

    logic [31:0] nxt_data;
    logic [3:0]  nxt_cw;
    logic [1:0]  nxt_lane;
    logic        nxt_full;

    logic [7:0]  sample;
    logic [31:0] placed_data;
    logic [3:0]  placed_cw;
    logic [31:0] cur_data;
    logic [3:0]  cur_cw;
    logic        flag_break;
    logic        complete;

    assign sample     = CONVERT_OFFSET ? (in_data ^ ADC_OFFSET) : in_data;
    assign flag_break = ALIGN_ON_FLAG && in_valid && in_flag && (lane != 2'd0);

    always_comb begin
        placed_data = a_data;
        placed_cw   = a_cw;
        placed_data[{lane, 3'b000} +: 8] = sample;
        placed_cw[lane] = in_flag;
    end

    // A is kept at pad value in every unused lane, so a partial word is
    // already padded the moment it has to be closed.
    always_comb begin
        word_valid = 1'b0;
        word_data  = a_data;
        word_cw    = a_cw;
        drop       = 1'b0;
        nxt_data   = a_data;
        nxt_cw     = a_cw;
        nxt_lane   = lane;
        nxt_full   = a_full;
        cur_data   = in_valid ? placed_data : a_data;
        cur_cw     = in_valid ? placed_cw : a_cw;
        complete   = flush || (lane == 2'd3);

        if (a_full) begin
            drop = in_valid;
            if (p_free) begin
                word_valid = 1'b1;
                nxt_data   = EMPTY_DATA;
                nxt_cw     = '0;
                nxt_lane   = 2'd0;
                nxt_full   = 1'b0;
            end
        end else if (flag_break) begin
            if (p_free) begin
                word_valid    = 1'b1;
                nxt_data      = EMPTY_DATA;
                nxt_data[7:0] = sample;
                nxt_cw        = {3'b000, in_flag};
                nxt_lane      = 2'd1;
            end else begin
                drop     = 1'b1;
                nxt_full = 1'b1;
                nxt_lane = 2'd0;
            end
        end else if (in_valid || (flush && lane != 2'd0)) begin
            if (complete) begin
                word_data = cur_data;
                word_cw   = cur_cw;
                nxt_lane  = 2'd0;
                if (p_free) begin
                    word_valid = 1'b1;
                    nxt_data   = EMPTY_DATA;
                    nxt_cw     = '0;
                end else begin
                    nxt_data = cur_data;
                    nxt_cw   = cur_cw;
                    nxt_full = 1'b1;
                end
            end else begin
                nxt_data = cur_data;
                nxt_cw   = cur_cw;
                nxt_lane = lane + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_data <= EMPTY_DATA;
            a_cw   <= '0;
            lane   <= 2'd0;
            a_full <= 1'b0;
        end else begin
            a_data <= nxt_data;
            a_cw   <= nxt_cw;
            lane   <= nxt_lane;
            a_full <= nxt_full;
        end
    end

endmodule

// File: rtl/adc_widthconv.sv
// ADC receive width converter: packs four converted samples per 36-bit FIFO
// word, with one pending output word and overrun drop counting.
module adc_widthconv
    import radio_pkg::*;
#(
    parameter bit CONVERT_OFFSET = 1'b1,
    parameter bit ALIGN_ON_FLAG  = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_flag,
    input  logic             flush,
    input  logic             out_full,
    output logic             out_wr_en,
    output logic [31:0]      out_data,
    output logic [3:0]       out_cw,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        p_valid;
    logic [31:0] p_data;
    logic [3:0]  p_cw;
    logic        wr;
    logic        p_free;

    logic        word_valid;
    logic [31:0] word_data;
    logic [3:0]  word_cw;
    logic        drop;

    assign wr     = p_valid && !out_full;
    assign p_free = !p_valid || wr;

    adc_lane_assembler #(
        .CONVERT_OFFSET (CONVERT_OFFSET),
        .ALIGN_ON_FLAG  (ALIGN_ON_FLAG)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_flag    (in_flag),
        .flush      (flush),
        .p_free     (p_free),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_cw    (word_cw),
        .drop       (drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid  <= 1'b0;
            p_data   <= '0;
            p_cw     <= '0;
            drop_cnt <= '0;
            word_cnt <= '0;
        end else begin
            // A word handed over replaces P even when P is written this cycle.
            if (word_valid) begin
                p_valid <= 1'b1;
                p_data  <= word_data;
                p_cw    <= word_cw;
            end else if (wr) begin
                p_valid <= 1'b0;
            end
            if (drop && drop_cnt != {CNT_W{1'b1}})
                drop_cnt <= drop_cnt + CNT_ONE;
            if (wr)
                word_cnt <= word_cnt + CNT_ONE;
        end
    end

    assign out_wr_en = wr;
    assign out_data  = p_data;
    assign out_cw    = p_cw;

endmodule

// File: tb/tb_adc_widthconv.sv
// Scoreboard bench: offset-converting/aligning DUT with narrow counters for
// directed cases, and a raw non-aligning DUT for the ramp.
module tb_adc_widthconv;
    import radio_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_reset, m_valid, m_flag, m_flush, m_full;
    logic [7:0]  m_din;
    logic        m_wr_en;
    logic [31:0] m_data;
    logic [3:0]  m_cw;
    logic [3:0]  m_drop, m_words;

    logic        r_reset, r_valid, r_flag, r_flush, r_full;
    logic [7:0]  r_din;
    logic        r_wr_en;
    logic [31:0] r_data;
    logic [3:0]  r_cw;
    logic [15:0] r_drop, r_words;

    int n_vec = 0;
    int n_err = 0;
    logic [35:0] m_q[$];
    logic [35:0] r_q[$];
    logic [7:0]  rb;

    adc_widthconv #(.CONVERT_OFFSET(1'b1), .ALIGN_ON_FLAG(1'b1), .CNT_W(4)) u_main (
        .clk(clk), .reset(m_reset), .in_valid(m_valid), .in_data(m_din),
        .in_flag(m_flag), .flush(m_flush), .out_full(m_full), .out_wr_en(m_wr_en),
        .out_data(m_data), .out_cw(m_cw), .drop_cnt(m_drop), .word_cnt(m_words)
    );

    adc_widthconv #(.CONVERT_OFFSET(1'b0), .ALIGN_ON_FLAG(1'b0), .CNT_W(16)) u_raw (
        .clk(clk), .reset(r_reset), .in_valid(r_valid), .in_data(r_din),
        .in_flag(r_flag), .flush(r_flush), .out_full(r_full), .out_wr_en(r_wr_en),
        .out_data(r_data), .out_cw(r_cw), .drop_cnt(r_drop), .word_cnt(r_words)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_wr_en) begin
            if (m_q.size() == 0) chk("main_unexpected_write", pack36(m_data, m_cw), 36'h0);
            else chk("main_word", pack36(m_data, m_cw), m_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (r_wr_en) begin
            if (r_q.size() == 0) chk("raw_unexpected_write", pack36(r_data, r_cw), 36'h0);
            else chk("raw_word", pack36(r_data, r_cw), r_q.pop_front());
        end
    end

    task automatic m_drive(input logic v, input logic [7:0] d, input logic f, input logic fl);
        @(posedge clk);
        #1;
        m_valid = v;
        m_din   = d;
        m_flag  = f;
        m_flush = fl;
    endtask

    task automatic m_idle(input int n);
        repeat (n) m_drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic m_push(input logic [31:0] d, input logic [3:0] cw);
        m_q.push_back(pack36(d, cw));
    endtask

    initial begin
        m_reset = 1'b1; m_valid = 1'b0; m_din = 8'h00; m_flag = 1'b0; m_flush = 1'b0; m_full = 1'b0;
        r_reset = 1'b1; r_valid = 1'b0; r_din = 8'h00; r_flag = 1'b0; r_flush = 1'b0; r_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", m_wr_en, 1'b0);
        chk("reset_data", m_data, 32'h0);
        chk("reset_cw", m_cw, 4'h0);
        chk("reset_drop", m_drop, 4'h0);
        chk("reset_words", m_words, 4'h0);
        m_reset = 1'b0;
        r_reset = 1'b0;

        // First word, flag on lane 0, write one cycle after the 4th sample.
        m_push(32'h03020100, 4'b0001);
        m_drive(1'b1, 8'h80, 1'b1, 1'b0);
        m_drive(1'b1, 8'h81, 1'b0, 1'b0);
        m_drive(1'b1, 8'h82, 1'b0, 1'b0);
        m_drive(1'b1, 8'h83, 1'b0, 1'b0);
        chk("t1_no_early_write", m_wr_en, 1'b0);
        m_idle(1);
        chk("t1_latency", m_wr_en, 1'b1);
        m_idle(2);
        chk("t1_word_cnt", m_words, 4'd1);

        // FIFO full across 12 samples: P, A, then four drops.
        m_full = 1'b1;
        m_push(32'h07060504, 4'b0000);
        m_push(32'h0b0a0908, 4'b0000);
        for (int i = 0; i < 12; i++) m_drive(1'b1, 8'h84 + 8'(i), 1'b0, 1'b0);
        m_idle(2);
        chk("t3_drop_cnt", m_drop, 4'd4);
        chk("t3_held", m_wr_en, 1'b0);
        m_full = 1'b0;
        #1;
        chk("t3_release_wr1", m_wr_en, 1'b1);
        @(posedge clk);
        #1;
        chk("t3_release_wr2", m_wr_en, 1'b1);
        @(posedge clk);
        #1;
        chk("t3_release_done", m_wr_en, 1'b0);
        chk("t3_word_cnt", m_words, 4'd3);

        // Flush a partial word, flush when empty, flush together with a sample.
        m_push(32'h00002010, 4'b0000);
        m_drive(1'b1, 8'h90, 1'b0, 1'b0);
        m_drive(1'b1, 8'ha0, 1'b0, 1'b0);
        m_drive(1'b0, 8'h00, 1'b0, 1'b1);
        m_idle(3);
        m_drive(1'b0, 8'h00, 1'b0, 1'b1);
        m_idle(3);
        chk("t4_empty_flush", m_words, 4'd4);
        m_push(32'h00000030, 4'b0000);
        m_drive(1'b1, 8'hb0, 1'b0, 1'b1);
        m_idle(3);
        chk("t4_word_cnt", m_words, 4'd5);

        // Flagged sample mid-word closes the word and starts lane 0.
        m_push(32'h00000201, 4'b0000);
        m_push(32'h08070605, 4'b0001);
        m_drive(1'b1, 8'h81, 1'b0, 1'b0);
        m_drive(1'b1, 8'h82, 1'b0, 1'b0);
        m_drive(1'b1, 8'h85, 1'b1, 1'b0);
        m_drive(1'b1, 8'h86, 1'b0, 1'b0);
        m_drive(1'b1, 8'h87, 1'b0, 1'b0);
        m_drive(1'b1, 8'h88, 1'b0, 1'b0);
        m_idle(3);
        chk("t5_word_cnt", m_words, 4'd7);

        // Flag break while P is busy drops the flagged sample; drops saturate.
        m_full = 1'b1;
        m_push(32'h03020100, 4'b0000);
        m_push(32'h00000504, 4'b0000);
        for (int i = 0; i < 6; i++) m_drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        m_drive(1'b1, 8'h86, 1'b1, 1'b0);
        m_idle(1);
        chk("t6_flag_drop", m_drop, 4'd5);
        for (int i = 0; i < 20; i++) m_drive(1'b1, 8'h40, 1'b0, 1'b0);
        m_idle(1);
        chk("t6_drop_saturate", m_drop, 4'hf);
        m_full = 1'b0;
        m_idle(4);
        chk("t6_word_cnt", m_words, 4'd9);

        // Reset with a word pending and two lanes filled.
        m_full = 1'b1;
        for (int i = 0; i < 6; i++) m_drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_reset = 1'b1;
        @(posedge clk);
        #1;
        m_reset = 1'b0;
        m_full  = 1'b0;
        chk("t7_wr_en", m_wr_en, 1'b0);
        chk("t7_data", m_data, 32'h0);
        chk("t7_cw", m_cw, 4'h0);
        chk("t7_drop", m_drop, 4'h0);
        chk("t7_words", m_words, 4'h0);
        m_push(32'h0b0a0908, 4'b0000);
        for (int i = 0; i < 4; i++) m_drive(1'b1, 8'h88 + 8'(i), 1'b0, 1'b0);
        m_idle(3);
        chk("t7_word_cnt", m_words, 4'd1);

        // Raw ramp: 256 samples into 64 words, no drops.
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            rb      = 8'(i);
            r_valid = 1'b1;
            r_din   = rb;
            r_flag  = (i % 8 == 0);
            if (i % 4 == 0)
                r_q.push_back(pack36({rb + 8'd3, rb + 8'd2, rb + 8'd1, rb},
                                     ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0000));
        end
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        r_flag  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ramp_drops", r_drop, 16'd0);
        chk("ramp_words", r_words, 16'd64);

        for (int t = 0; t < 20 && (m_q.size() != 0 || r_q.size() != 0); t++) @(posedge clk);
        chk("main_leftover", m_q.size(), 0);
        chk("raw_leftover", r_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
